// File: rtl/kc_tap_upload.sv
// KC-TAP upload engine: streams a 16-byte header followed by numbered 128-byte
// blocks from system memory to the HPS through the hps_io upload channel.
module kc_tap_upload #(
   parameter logic [7:0] TAP_INDEX = 8'h01,
   parameter int         HDR_LEN   = 16,
   parameter int         BLK_DATA  = 128
) (
   input  logic        cpuclk,
   input  logic        reset_n,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   input  logic [15:0] cfg_addr,
   input  logic [7:0]  cfg_blocks,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        mem_valid,
   output logic        busy,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_BLKNUM = 3'd2,
      S_FETCH  = 3'd3,
      S_DATA   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        act_q;
   logic [3:0]  pos_q, pos_d;
   logic [15:0] ptr_q, ptr_d;
   logic [8:0]  rem_q, rem_d;
   logic [7:0]  blk_q, blk_d;
   logic [7:0]  k_q, k_d;
   logic [24:0] off_q, off_d;
   logic [7:0]  din_q, din_d;
   logic        wait_q, wait_d;
   logic        mem_rd_q, mem_rd_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        busy_q, busy_d;
   logic        error_q, error_d;

   logic        act_s, start_s, rd_ok_s, streaming_s;
   logic [7:0]  blk_next_s;

   function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'hC3;
         4'd1:    b = 8'h4B;
         4'd2:    b = 8'h43;
         4'd3:    b = 8'h2D;
         4'd4:    b = 8'h54;
         4'd5:    b = 8'h41;
         4'd6:    b = 8'h50;
         4'd7:    b = 8'h45;
         4'd8:    b = 8'h20;
         4'd9:    b = 8'h62;
         4'd10:   b = 8'h79;
         4'd11:   b = 8'h20;
         4'd12:   b = 8'h41;
         4'd13:   b = 8'h46;
         4'd14:   b = 8'h2E;
         4'd15:   b = 8'h20;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   assign act_s       = ioctl_upload && (ioctl_index == TAP_INDEX);
   assign start_s     = act_s && !act_q && (state_q == S_IDLE);
   assign rd_ok_s     = ioctl_rd && !wait_q;
   assign streaming_s = (state_q == S_HDR) || (state_q == S_BLKNUM) || (state_q == S_DATA);
   assign blk_next_s  = sat_inc(blk_q);

   // State and output registers, synchronous active-low reset
   always_ff @(posedge cpuclk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         act_q      <= 1'b0;
         pos_q      <= 4'd0;
         ptr_q      <= 16'd0;
         rem_q      <= 9'd0;
         blk_q      <= 8'd0;
         k_q        <= 8'd0;
         off_q      <= 25'd0;
         din_q      <= 8'd0;
         wait_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= 16'd0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_s;
         pos_q      <= pos_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         blk_q      <= blk_d;
         k_q        <= k_d;
         off_q      <= off_d;
         din_q      <= din_d;
         wait_q     <= wait_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      ptr_d      = ptr_q;
      rem_d      = rem_q;
      blk_d      = blk_q;
      k_d        = k_q;
      off_d      = off_q;
      din_d      = din_q;
      wait_d     = wait_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      busy_d     = busy_q;
      error_d    = error_q;

      // ioctl_addr is the stream offset of the byte being consumed
      if ((ioctl_rd && wait_q) || (rd_ok_s && streaming_s && (ioctl_addr != off_q))) begin
         error_d = 1'b1;
      end else begin
         error_d = error_q;
      end
      if (rd_ok_s && streaming_s) begin
         off_d = off_q + 25'd1;
      end else begin
         off_d = off_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_HDR;
               pos_d   = 4'd0;
               ptr_d   = cfg_addr;
               rem_d   = (cfg_blocks == 8'd0) ? 9'd256 : {1'b0, cfg_blocks};
               blk_d   = 8'd0;
               k_d     = 8'd0;
               off_d   = 25'd0;
               din_d   = hdr_byte(4'd0);
               wait_d  = 1'b0;
               busy_d  = 1'b1;
               error_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR: begin
            if (rd_ok_s) begin
               if (pos_q == 4'(HDR_LEN - 1)) begin
                  state_d = S_BLKNUM;
                  blk_d   = 8'd1;
                  din_d   = (rem_q == 9'd1) ? 8'hFF : 8'd1;
               end else begin
                  pos_d = pos_q + 4'd1;
                  din_d = hdr_byte(pos_q + 4'd1);
               end
            end else begin
               state_d = S_HDR;
            end
         end
         S_BLKNUM: begin
            if (rd_ok_s) begin
               state_d    = S_FETCH;
               k_d        = 8'd0;
               wait_d     = 1'b1;
               mem_rd_d   = 1'b1;
               mem_addr_d = ptr_q;
            end else begin
               state_d = S_BLKNUM;
            end
         end
         S_FETCH: begin
            if (mem_valid) begin
               state_d = S_DATA;
               din_d   = mem_data;
               ptr_d   = ptr_q + 16'd1;
               wait_d  = 1'b0;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DATA: begin
            if (rd_ok_s) begin
               k_d = k_q + 8'd1;
               if (k_q < 8'(BLK_DATA - 1)) begin
                  state_d    = S_FETCH;
                  wait_d     = 1'b1;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = ptr_q;
               end else if (rem_q > 9'd1) begin
                  state_d = S_BLKNUM;
                  rem_d   = rem_q - 9'd1;
                  blk_d   = blk_next_s;
                  din_d   = (rem_q == 9'd2) ? 8'hFF : blk_next_s;
               end else begin
                  state_d = S_DONE;
                  din_d   = 8'd0;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
            din_d   = 8'd0;
            wait_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            din_d   = 8'd0;
            wait_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // Host closing the session overrides everything, including a same-cycle read
      if ((state_q != S_IDLE) && !ioctl_upload) begin
         state_d  = S_IDLE;
         off_d    = off_q;
         din_d    = 8'd0;
         wait_d   = 1'b0;
         mem_rd_d = 1'b0;
         busy_d   = 1'b0;
         error_d  = error_q;
      end else begin
         busy_d = busy_d;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;
   assign busy       = busy_q;
   assign error      = error_q;

endmodule

// File: tb/tb_kc_tap_upload.sv
// Directed self-checking bench for kc_tap_upload with a variable-latency memory model.
module tb_kc_tap_upload;

   logic        cpuclk = 1'b0;
   logic        reset_n;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [15:0] cfg_addr;
   logic [7:0]  cfg_blocks;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_valid;
   logic        busy;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   int          mem_lat = 3;
   int          pend_cnt = 0;
   logic [15:0] pend_addr = 16'd0;
   int          mem_cnt = 0;
   logic [15:0] mem_log [0:1023];

   logic [7:0] hdr [0:15] = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                              8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};

   kc_tap_upload dut (
      .cpuclk       (cpuclk),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .cfg_addr     (cfg_addr),
      .cfg_blocks   (cfg_blocks),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_valid    (mem_valid),
      .busy         (busy),
      .error        (error)
   );

   always #5 cpuclk = ~cpuclk;

   // Memory returns the low address byte mem_lat cycles after a request
   always @(posedge cpuclk) begin
      mem_valid <= 1'b0;
      if (pend_cnt > 0) begin
         if (pend_cnt == 1) begin
            mem_valid <= 1'b1;
            mem_data  <= pend_addr[7:0];
         end
         pend_cnt <= pend_cnt - 1;
      end
      if (mem_rd === 1'b1) begin
         pend_addr <= mem_addr;
         pend_cnt  <= mem_lat;
         mem_log[mem_cnt % 1024] <= mem_addr;
         mem_cnt   <= mem_cnt + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic get_byte(input int off, output logic [7:0] b, output bit to, output bit saw_wait);
      int n = 0;
      to = 1'b0;
      saw_wait = 1'b0;
      while (ioctl_wait === 1'b1 && n < 100) begin
         saw_wait = 1'b1;
         @(negedge cpuclk);
         n++;
      end
      if (ioctl_wait !== 1'b0) to = 1'b1;
      b = ioctl_din;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'(off);
      @(negedge cpuclk);
      ioctl_rd = 1'b0;
   endtask

   task automatic start_session(input logic [15:0] a, input logic [7:0] nb);
      ioctl_upload = 1'b0;
      @(negedge cpuclk);
      cfg_addr     = a;
      cfg_blocks   = nb;
      ioctl_index  = 8'h01;
      ioctl_upload = 1'b1;
      @(negedge cpuclk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'h00; ioctl_rd = 1'b0;
      ioctl_addr = 25'd0; cfg_addr = 16'd0; cfg_blocks = 8'd0;
      repeat (2) @(negedge cpuclk);
      n_checks++;
      if ({ioctl_din, ioctl_wait, mem_rd, mem_addr, busy, error} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: din=%h wait=%b mem_rd=%b mem_addr=%h busy=%b error=%b, required all zero",
                  ioctl_din, ioctl_wait, mem_rd, mem_addr, busy, error);
      end
      reset_n = 1'b1;
      @(negedge cpuclk);
   endtask

   task automatic test_header;
      logic [7:0] b;
      bit to, sw, any_wait;
      any_wait = 1'b0;
      start_session(16'h0200, 8'd1);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL hdr_busy: got %b, required 1", busy); end
      for (int i = 0; i < 16; i++) begin
         get_byte(i, b, to, sw);
         any_wait |= sw | to;
         n_checks++;
         if (b !== hdr[i]) begin
            n_fail++;
            $display("FAIL hdr_byte[%0d]: got %h, required %h", i, b, hdr[i]);
         end
      end
      n_checks++;
      if (any_wait !== 1'b0) begin n_fail++; $display("FAIL hdr_wait: wait seen high during header, required never"); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL hdr_busy_end: got %b, required 1", busy); end
   endtask

   task automatic test_single_block;
      logic [7:0] b;
      bit to, sw, any_to;
      int base, bad;
      any_to = 1'b0; bad = 0;
      base = mem_cnt;
      mem_lat = 3;
      get_byte(16, b, to, sw);
      n_checks++;
      if (b !== 8'hFF) begin n_fail++; $display("FAIL blk1_num: got %h, required ff", b); end
      for (int i = 17; i < 145; i++) begin
         get_byte(i, b, to, sw);
         any_to |= to;
         n_checks++;
         if (b !== 8'(i - 17)) begin
            n_fail++;
            $display("FAIL blk1_data[%0d]: got %h, required %h", i, b, 8'(i - 17));
         end
      end
      n_checks++;
      if (any_to !== 1'b0) begin n_fail++; $display("FAIL blk1_timeout: wait stuck high, required data"); end
      n_checks++;
      if (mem_cnt - base !== 128) begin
         n_fail++; $display("FAIL blk1_rd_count: got %0d mem_rd pulses, required 128", mem_cnt - base);
      end
      for (int j = 0; j < 128; j++) begin
         if (mem_log[(base + j) % 1024] !== 16'h0200 + 16'(j)) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL blk1_mem_addr: %0d addresses wrong, required 0200..027f", bad); end
      get_byte(145, b, to, sw);
      n_checks++;
      if (b !== 8'h00 || ioctl_wait !== 1'b0) begin
         n_fail++; $display("FAIL blk1_done: got din=%h wait=%b, required 00/0", b, ioctl_wait);
      end
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL blk1_error: got %b, required 0", error); end
      ioctl_upload = 1'b0;
      @(negedge cpuclk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL blk1_end_busy: got %b, required 0", busy); end
   endtask

   task automatic test_multi_block;
      logic [7:0] b, exp;
      logic [15:0] a;
      bit to, sw, any_to;
      int base, blk, r;
      any_to = 1'b0;
      mem_lat = 2;
      start_session(16'hFFC0, 8'd3);
      base = mem_cnt;
      for (int o = 0; o < 403; o++) begin
         get_byte(o, b, to, sw);
         any_to |= to;
         if (o < 16) begin
            exp = hdr[o];
         end else begin
            blk = (o - 16) / 129;
            r   = (o - 16) % 129;
            if (r == 0) begin
               exp = (blk == 2) ? 8'hFF : 8'(blk + 1);
            end else begin
               a   = 16'hFFC0 + 16'(blk * 128 + r - 1);
               exp = a[7:0];
            end
         end
         n_checks++;
         if (b !== exp) begin
            n_fail++; $display("FAIL multi_byte[%0d]: got %h, required %h", o, b, exp);
         end
      end
      n_checks++;
      if (any_to !== 1'b0) begin n_fail++; $display("FAIL multi_timeout: wait stuck high, required data"); end
      n_checks++;
      if (mem_cnt - base !== 384) begin
         n_fail++; $display("FAIL multi_rd_count: got %0d, required 384", mem_cnt - base);
      end
      n_checks++;
      if (mem_log[(base + 63) % 1024] !== 16'hFFFF || mem_log[(base + 64) % 1024] !== 16'h0000) begin
         n_fail++; $display("FAIL multi_wrap: got %h then %h, required ffff then 0000",
                            mem_log[(base + 63) % 1024], mem_log[(base + 64) % 1024]);
      end
      get_byte(403, b, to, sw);
      n_checks++;
      if (b !== 8'h00 || ioctl_wait !== 1'b0) begin
         n_fail++; $display("FAIL multi_done: got din=%h wait=%b, required 00/0", b, ioctl_wait);
      end
      get_byte(404, b, to, sw);
      n_checks++;
      if (error !== 1'b0 || ioctl_din !== 8'h00) begin
         n_fail++; $display("FAIL multi_past_end: got error=%b din=%h, required 0/00", error, ioctl_din);
      end
   endtask

   task automatic test_abort;
      logic [7:0] b;
      bit to, sw, bad;
      int cnt0;
      bad = 1'b0;
      mem_lat = 2;
      start_session(16'h0200, 8'd1);
      for (int o = 0; o < 17; o++) get_byte(o, b, to, sw);
      n_checks++;
      if (mem_rd !== 1'b1 || ioctl_wait !== 1'b1) begin
         n_fail++; $display("FAIL abort_fetch: got mem_rd=%b wait=%b, required 1/1", mem_rd, ioctl_wait);
      end
      ioctl_upload = 1'b0;
      @(negedge cpuclk);
      n_checks++;
      if (busy !== 1'b0 || ioctl_wait !== 1'b0) begin
         n_fail++; $display("FAIL abort_busy: got busy=%b wait=%b, required 0/0", busy, ioctl_wait);
      end
      cnt0 = mem_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge cpuclk);
         if (busy !== 1'b0 || ioctl_wait !== 1'b0 || ioctl_din !== 8'h00 || mem_rd !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad !== 1'b0 || mem_cnt !== cnt0) begin
         n_fail++; $display("FAIL abort_late_valid: late mem_valid disturbed outputs, required idle");
      end
      ioctl_upload = 1'b1;
      @(negedge cpuclk);
      n_checks++;
      if (busy !== 1'b1 || ioctl_din !== 8'hC3 || ioctl_wait !== 1'b0) begin
         n_fail++; $display("FAIL abort_restart: got busy=%b din=%h wait=%b, required 1/c3/0",
                            busy, ioctl_din, ioctl_wait);
      end
   endtask

   task automatic test_protocol_error;
      logic [7:0] b;
      bit to, sw;
      mem_lat = 3;
      start_session(16'h0210, 8'd1);
      for (int o = 0; o < 17; o++) get_byte(o, b, to, sw);
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL proto_pre: got error=%b, required 0", error); end
      ioctl_rd = 1'b1; ioctl_addr = 25'd17;
      @(negedge cpuclk);
      ioctl_rd = 1'b0;
      n_checks++;
      if (error !== 1'b1) begin n_fail++; $display("FAIL proto_error: got %b, required 1", error); end
      get_byte(17, b, to, sw);
      n_checks++;
      if (b !== 8'h10 || to !== 1'b0) begin n_fail++; $display("FAIL proto_byte17: got %h, required 10", b); end
      get_byte(18, b, to, sw);
      n_checks++;
      if (b !== 8'h11 || to !== 1'b0) begin n_fail++; $display("FAIL proto_byte18: got %h, required 11", b); end
      n_checks++;
      if (error !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b, required 1", error); end
   endtask

   task automatic test_addr_mismatch;
      logic [7:0] b;
      bit to, sw;
      start_session(16'h0200, 8'd1);
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL addr_clear: got error=%b, required 0", error); end
      get_byte(5, b, to, sw);
      n_checks++;
      if (error !== 1'b1 || ioctl_din !== 8'h4B) begin
         n_fail++; $display("FAIL addr_mismatch: got error=%b din=%h, required 1/4b", error, ioctl_din);
      end
   endtask

   task automatic test_wrong_index_reset;
      logic [7:0] b;
      bit to, sw, bad;
      int cnt0;
      bad = 1'b0;
      ioctl_upload = 1'b0;
      @(negedge cpuclk);
      cnt0 = mem_cnt;
      ioctl_index = 8'h00; ioctl_upload = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge cpuclk);
         if (busy !== 1'b0 || mem_rd !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad !== 1'b0 || mem_cnt !== cnt0) begin
         n_fail++; $display("FAIL wrong_index: session activity seen, required none");
      end
      start_session(16'h0300, 8'd2);
      for (int o = 0; o < 16; o++) get_byte(o, b, to, sw);
      get_byte(99, b, to, sw);
      for (int o = 17; o < 20; o++) get_byte(o, b, to, sw);
      n_checks++;
      if (mem_rd !== 1'b1 || error !== 1'b1) begin
         n_fail++; $display("FAIL reset_setup: got mem_rd=%b error=%b, required 1/1", mem_rd, error);
      end
      reset_n = 1'b0;
      @(negedge cpuclk);
      n_checks++;
      if ({ioctl_din, ioctl_wait, mem_rd, mem_addr, busy, error} !== 28'd0) begin
         n_fail++;
         $display("FAIL midblock_reset: din=%h wait=%b mem_rd=%b mem_addr=%h busy=%b error=%b, required all zero",
                  ioctl_din, ioctl_wait, mem_rd, mem_addr, busy, error);
      end
      cnt0 = mem_cnt;
      repeat (4) @(negedge cpuclk);
      ioctl_upload = 1'b0;
      @(negedge cpuclk);
      reset_n = 1'b1;
      repeat (3) @(negedge cpuclk);
      n_checks++;
      if (busy !== 1'b0 || mem_cnt !== cnt0 || ioctl_din !== 8'h00 || ioctl_wait !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle: busy=%b extra_rd=%0d din=%h wait=%b, required idle",
                            busy, mem_cnt - cnt0, ioctl_din, ioctl_wait);
      end
   endtask

   initial begin
      @(negedge cpuclk);
      test_reset();
      test_header();
      test_single_block();
      test_multi_block();
      test_abort();
      test_protocol_error();
      test_addr_mismatch();
      test_wrong_index_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
